// File: rtl/axil_fifo_master.sv
// rtl/axil_fifo_master.sv - AXI4-Lite master draining/filling a remote memory-mapped FIFO bridge
// Optional response checking: define AXIL_FIFO_MASTER_RESP_CHK_EN.

module axil_fifo_master_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module axil_fifo_master #(
  parameter int          C_DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int          TX_DEPTH      = 8,
  parameter int          RX_DEPTH      = 8,
  parameter int          POLL_INTERVAL = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [31:0]               awaddr,
  output logic [3:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [C_DATA_WIDTH-1:0]   wdata,
  output logic [C_DATA_WIDTH/8-1:0] wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [31:0]               araddr,
  output logic [3:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [C_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [C_DATA_WIDTH-1:0]   tx_wdata,
  input  logic                      tx_wena,
  output logic                      tx_full,
  output logic [C_DATA_WIDTH-1:0]   rx_rdata,
  input  logic                      rx_rena,
  output logic                      rx_empty,
  output logic                      busy,
  output logic                      err,
  input  logic                      err_clr
);
  localparam int          BYTES       = C_DATA_WIDTH / 8;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR;
  localparam logic [31:0] WRITE_ADDR  = BASE_ADDR + 32'(BYTES);
  localparam logic [31:0] READ_ADDR   = BASE_ADDR + 32'(2 * BYTES);
  localparam int          WCW         = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_WR_AW, S_WR_B, S_RD_AR, S_RD_R, S_WAIT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              aw_done;
  logic              w_done;
  logic              aw_hs;
  logic              w_hs;
  logic              remote_empty_q;
  logic [WCW-1:0]    wait_cnt;
  logic              busy_q;
  logic              b_err;
  logic              r_err;

  logic [C_DATA_WIDTH-1:0] tx_head;
  logic              tx_empty;
  logic              tx_pop;
  logic              rx_full;
  logic              rx_push;

  assign awprot = 4'b0;
  assign arprot = 4'b0;
  assign wstrb  = '1;
  assign busy   = busy_q;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign tx_pop  = (state == S_WR_B) && bvalid;
  // An errored read is dropped so RX only ever holds good data.
  assign rx_push = (state == S_RD_R) && rvalid && !r_err;

  axil_fifo_master_fifo #(.WIDTH(C_DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wena),
    .din   (tx_wdata),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  axil_fifo_master_fifo #(.WIDTH(C_DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rdata),
    .pop   (rx_rena),
    .dout  (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

`ifdef AXIL_FIFO_MASTER_RESP_CHK_EN
  logic err_q;

  assign b_err = (bresp != 2'b00);
  assign r_err = (rresp != 2'b00);
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else if ((state == S_WR_B && bvalid && b_err) ||
                 ((state == S_R || state == S_RD_R) && rvalid && r_err)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_resp;

  assign b_err       = 1'b0;
  assign r_err       = 1'b0;
  assign err         = 1'b0;
  assign unused_resp = ^{bresp, rresp, err_clr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      remote_empty_q <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != S_WAIT);
      if (state == S_R && rvalid) remote_empty_q <= rdata[1];
    end
  end

  // Write channels complete independently; remember which one already handshook.
  always_ff @(posedge clk) begin
    if (rst || state != S_WR_AW) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= WCW'(POLL_INTERVAL - 1);
    else if (wait_cnt != '0)    wait_cnt <= wait_cnt - WCW'(1);
  end

  always_comb begin
    state_next = state;
    awvalid    = 1'b0;
    awaddr     = '0;
    wvalid     = 1'b0;
    wdata      = '0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    araddr     = '0;
    rready     = 1'b0;
    case (state)
      S_IDLE: state_next = S_AR;
      S_AR: begin
        arvalid = 1'b1;
        araddr  = STATUS_ADDR;
        if (arready) state_next = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          // A failed status read carries no trustworthy flags, so back off.
          if (r_err)                        state_next = S_WAIT;
          else if (!tx_empty && !rdata[3])  state_next = S_WR_AW;
          else if (!rdata[1] && !rx_full)   state_next = S_RD_AR;
          else                              state_next = S_WAIT;
        end
      end
      S_WR_AW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        awaddr  = WRITE_ADDR;
        wdata   = tx_head;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = S_WR_B;
      end
      S_WR_B: begin
        bready = 1'b1;
        if (bvalid) state_next = (!remote_empty_q && !rx_full) ? S_RD_AR : S_IDLE;
      end
      S_RD_AR: begin
        arvalid = 1'b1;
        araddr  = READ_ADDR;
        if (arready) state_next = S_RD_R;
      end
      S_RD_R: begin
        rready = 1'b1;
        if (rvalid) state_next = S_IDLE;
      end
      S_WAIT: if (wait_cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axil_fifo_master.sv
// tb/tb_axil_fifo_master.sv - directed bench with a remote-slave model and per-cycle scoreboard
module tb_axil_fifo_master;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr, araddr, wdata, rdata, tx_wdata, rx_rdata;
  logic [3:0]  awprot, arprot, wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        tx_wena, tx_full, rx_rena, rx_empty, busy, err, err_clr;

  axil_fifo_master #(.C_DATA_WIDTH(32), .BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(8),
                     .POLL_INTERVAL(16)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tx_wdata(tx_wdata), .tx_wena(tx_wena), .tx_full(tx_full),
    .rx_rdata(rx_rdata), .rx_rena(rx_rena), .rx_empty(rx_empty),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: local FIFO contents, remote slave state, transaction counters.
  logic [31:0] mtx[$];
  logic [31:0] mrx[$];
  logic [31:0] rdq[$];
  bit          wr_full = 1'b0;
  int          aw_delay = 0;
  bit          bresp_err_once = 1'b0;
  int          n_status = 0, n_writes = 0, n_rd = 0, split_cnt = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_rd_addr = '0;
  logic [3:0]  last_wstrb = '0, last_status = 4'h2;

  bit          r_pending = 0, r_is_status = 0, aw_got = 0, w_got = 0, b_pending = 0;
  logic [31:0] r_data = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [1:0]  b_resp_val = '0;
  int          w_age = 0, wr_this_poll = 0, rd_this_poll = 0;

  logic        p_rst, p_arvalid, p_arready, p_rvalid, p_rready, p_awvalid, p_awready;
  logic        p_wvalid, p_wready, p_bvalid, p_bready, p_tx_wena, p_rx_rena;
  logic [31:0] p_araddr, p_awaddr, p_wdata, p_tx_wdata;
  logic [3:0]  p_wstrb;

  // Remote slave + scoreboard: events of the last rising edge are processed at negedge+3.
  initial begin
    bit tx_was_full, rx_was_empty, rx_was_full;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    p_rst = 1; p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0;
    p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0; p_bvalid = 0; p_bready = 0;
    p_tx_wena = 0; p_rx_rena = 0; p_araddr = '0; p_awaddr = '0; p_wdata = '0;
    p_tx_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge clk); #3;
      if (!p_rst) begin
        tx_was_full  = (mtx.size() == 8);
        rx_was_empty = (mrx.size() == 0);
        rx_was_full  = (mrx.size() == 8);
        if (p_bvalid && p_bready) begin
          chk("wr_addr", cap_awaddr, BASE + 32'd4);
          if (mtx.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            chk("wr_data", cap_wdata, mtx[0]);
            void'(mtx.pop_front());
          end
          last_awaddr = cap_awaddr; last_wdata = cap_wdata; last_wstrb = cap_wstrb;
          n_writes++; wr_this_poll++;
          chk("one_wr_per_poll", wr_this_poll <= 1, 1);
          aw_got = 0; w_got = 0; b_pending = 0;
        end
        if (p_tx_wena && !tx_was_full) mtx.push_back(p_tx_wdata);
        if (p_rx_rena && !rx_was_empty) void'(mrx.pop_front());
        if (p_rvalid && p_rready) begin
          if (r_is_status) begin
            last_status = r_data[3:0]; n_status++; wr_this_poll = 0; rd_this_poll = 0;
          end else begin
            if (!rx_was_full) mrx.push_back(r_data);
            n_rd++;
          end
          r_pending = 0;
        end
        if (p_arvalid && p_arready) begin
          r_pending = 1;
          if (p_araddr == BASE) begin
            r_is_status = 1;
            r_data = {28'h0, wr_full, 1'b0, rdq.size() == 0, rdq.size() == 1};
          end else begin
            r_is_status = 0;
            chk("rd_addr", p_araddr, BASE + 32'd8);
            rd_this_poll++;
            chk("one_rd_per_poll", rd_this_poll <= 1, 1);
            chk("rd_only_when_nonempty", last_status[1], 0);
            last_rd_addr = p_araddr;
            r_data = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
          end
        end
        if (p_awvalid && p_awready) begin
          aw_got = 1; cap_awaddr = p_awaddr;
          chk("wr_only_when_room", last_status[3], 0);
        end
        if (p_wvalid && p_wready) begin
          w_got = 1; w_age = 0; cap_wdata = p_wdata; cap_wstrb = p_wstrb;
        end
        if (w_got) w_age++;
        if (aw_got && w_got && !b_pending) begin
          b_pending = 1;
          b_resp_val = bresp_err_once ? 2'd2 : 2'd0;
          bresp_err_once = 0;
        end
        if (!rst) begin
          chk("tx_full", tx_full, mtx.size() == 8);
          chk("rx_empty", rx_empty, mrx.size() == 0);
          if (mrx.size() > 0) chk("rx_rdata", rx_rdata, mrx[0]);
          chk("wstrb", wstrb, 4'hF);
          chk("prot", {awprot, arprot}, 0);
          if (p_arvalid && !p_arready) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
          if (p_awvalid && !p_awready) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
          if (p_wvalid && !p_wready)   chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
          if (awvalid && !wvalid) split_cnt++;
        end
      end
      arready = arvalid && !r_pending;
      rvalid  = r_pending;
      rdata   = r_pending ? r_data : 32'h0;
      wready  = wvalid;
      awready = awvalid && (aw_delay == 0 || (w_got && w_age >= aw_delay));
      bvalid  = b_pending;
      bresp   = b_pending ? b_resp_val : 2'd0;
      p_rst = rst; p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
      p_rvalid = rvalid; p_rready = rready; p_awvalid = awvalid; p_awready = awready;
      p_awaddr = awaddr; p_wvalid = wvalid; p_wready = wready; p_wdata = wdata;
      p_wstrb = wstrb; p_bvalid = bvalid; p_bready = bready;
      p_tx_wena = tx_wena; p_tx_wdata = tx_wdata; p_rx_rena = rx_rena;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // which: 0 = writes, 1 = status polls, 2 = data reads
  task automatic wait_for(input string name, input int which, input int target, input int bound);
    int cur;
    for (int i = 0; i < bound; i++) begin
      tick();
      cur = (which == 0) ? n_writes : (which == 1) ? n_status : n_rd;
      if (cur >= target) return;
    end
    chk(name, 0, 1);
  endtask

  task automatic push_tx(input logic [31:0] v);
    tx_wena = 1'b1; tx_wdata = v;
    tick();
    tx_wena = 1'b0;
  endtask

  initial begin
    int w0, s0, r0, cnt;
    rst = 1'b1; tx_wena = 1'b0; tx_wdata = '0; rx_rena = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
      chk("rst_flags", {rx_empty, tx_full, busy, err}, 4'b1000);
      chk("rst_addrs", {araddr, awaddr}, 0);
      chk("rst_wdata", wdata, 0);
    end

    // Release reset with a word pushed in the same cycle; IDLE occupies this first cycle.
    rst = 1'b0;
    chk("idle_cycle_no_ar", arvalid, 0);
    push_tx(32'hA5A5_0001);
    chk("first_status_ar", {arvalid, araddr}, {1'b1, BASE});
    chk("busy_after_idle", busy, 1);
    wait_for("timeout_first_write", 0, 1, 200);
    chk("wr1_awaddr", last_awaddr, 32'h0000_1004);
    chk("wr1_wdata", last_wdata, 32'hA5A5_0001);
    chk("wr1_wstrb", last_wstrb, 4'hF);

    cnt = 0;
    for (int i = 0; i < 100 && busy; i++) tick();
    for (int i = 0; i < 100 && !busy; i++) begin cnt++; tick(); end
    chk("wait_len", cnt, 16);

    // Remote read FIFO holds one word.
    r0 = n_rd;
    rdq.push_back(32'h0000_1234);
    wait_for("timeout_read", 2, r0 + 1, 200);
    chk("rd_araddr", last_rd_addr, 32'h0000_1008);
    chk("rd_rx_empty", rx_empty, 0);
    chk("rd_rx_rdata", rx_rdata, 32'h0000_1234);
    rx_rena = 1'b1;
    tick();
    rx_rena = 1'b0;
    tick();
    chk("rx_popped_empty", rx_empty, 1);

    // Remote write FIFO full and remote read FIFO empty: nothing may be issued.
    wr_full = 1'b1;
    s0 = n_status; w0 = n_writes; r0 = n_rd;
    push_tx(32'hBEEF_0002);
    wait_for("timeout_full_polls", 1, s0 + 2, 300);
    chk("full_no_write", n_writes, w0);
    chk("full_no_read", n_rd, r0);
    chk("full_status", last_status, 4'hA);
    chk("full_tx_kept", tx_full, 0);
    wr_full = 1'b0;
    wait_for("timeout_retained_write", 0, w0 + 1, 200);
    chk("retained_wdata", last_wdata, 32'hBEEF_0002);

    // awready lags wready by three cycles.
    aw_delay = 3; split_cnt = 0; w0 = n_writes;
    push_tx(32'hC0DE_0003);
    wait_for("timeout_split_write", 0, w0 + 1, 200);
    chk("split_cycles", split_cnt, 3);
    chk("split_wdata", last_wdata, 32'hC0DE_0003);
    for (int i = 0; i < 20; i++) tick();
    chk("split_single_write", n_writes, w0 + 1);
    aw_delay = 0;

    // Fill TX while the remote is full, then overflow by one.
    wr_full = 1'b1; w0 = n_writes;
    tx_wena = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_wdata = 32'hE000_0000 + i;
      tick();
    end
    tx_wena = 1'b0;
    tick();
    chk("tx_full_at_8", tx_full, 1);
    push_tx(32'hDEAD_0009);
    chk("tx_full_after_9th", tx_full, 1);

`ifdef AXIL_FIFO_MASTER_RESP_CHK_EN
    bresp_err_once = 1'b1;
`endif
    wr_full = 1'b0;
    wait_for("timeout_drain_first", 0, w0 + 1, 200);
    tick();
`ifdef AXIL_FIFO_MASTER_RESP_CHK_EN
    chk("err_set_on_bresp", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
`else
    chk("err_tied_low", err, 0);
`endif
    wait_for("timeout_drain_all", 0, w0 + 8, 1500);
    for (int i = 0; i < 60; i++) tick();
    chk("ninth_push_dropped", n_writes, w0 + 8);
    chk("drain_last_wdata", last_wdata, 32'hE000_0007);
    chk("total_writes", n_writes, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
